// File: rtl/jtdsp16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtdsp16_pkg : shared types and constants for the DSP16 cache slice   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package jtdsp16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_LOOP = 2'd2
    } state_t;

    localparam int CACHE_DEPTH = 15;
    localparam int KW          = 7;
    localparam int NIW         = 4;

endpackage
`default_nettype wire

// File: rtl/jtdsp16_cache_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtdsp16_cache_ctrl_if : decoder/ROM side bus of the cache sequencer  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface jtdsp16_cache_ctrl_if #(
    parameter int IW = 16
);
    import jtdsp16_pkg::*;

    logic           cen;
    logic           do_en;
    logic           redo_en;
    logic [NIW-1:0] ni;
    logic [KW-1:0]  k;
    logic [IW-1:0]  rom_dout;
    logic [IW-1:0]  cache_dout;
    logic           cache_sel;
    logic           pc_hold;
    logic           busy;
    logic           err;

    modport master (
        output cen, do_en, redo_en, ni, k, rom_dout,
        input  cache_dout, cache_sel, pc_hold, busy, err
    );

    modport slave (
        input  cen, do_en, redo_en, ni, k, rom_dout,
        output cache_dout, cache_sel, pc_hold, busy, err
    );

endinterface
`default_nettype wire

// File: rtl/jtdsp16_cache_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtdsp16_cache_mem : DEPTH x IW register file, sync write, async read |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module jtdsp16_cache_mem #(
    parameter int DEPTH = 15,
    parameter int IW    = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          cen,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] din,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] dout
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [IW-1:0] mem [DEPTH];

    // Contents are never cleared; the controller's valid flag guards them.
    always_ff @(posedge clk) begin
        if (cen && we && (waddr <= LAST)) begin
            mem[waddr] <= din;
        end
    end

    assign dout = (raddr <= LAST) ? mem[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/jtdsp16_cache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtdsp16_cache_ctrl : do/redo loop sequencer for the DSP16 I-cache    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module jtdsp16_cache_ctrl
    import jtdsp16_pkg::*;
#(
    parameter int DEPTH = CACHE_DEPTH,
    parameter int IW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    jtdsp16_cache_ctrl_if.slave   bus
);

    state_t         state, state_nx;
    logic [NIW-1:0] wr_ptr, wr_ptr_nx;
    logic [NIW-1:0] rd_ptr, rd_ptr_nx;
    logic [NIW-1:0] ni_r, ni_nx;
    logic [KW-1:0]  cnt, cnt_nx;
    logic           cache_valid, valid_nx;
    logic           err_r, err_nx;
    logic           mem_we;
    logic           do_ok;
    logic           redo_ok;
    logic           req;
    logic [IW-1:0]  mem_rdata;

    assign req     = bus.do_en | bus.redo_en;
    assign do_ok   = (bus.ni != '0) && (bus.k != '0);
    assign redo_ok = cache_valid && (bus.k != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ni_r        <= '0;
            cnt         <= '0;
            cache_valid <= 1'b0;
            err_r       <= 1'b0;
        end else if (bus.cen) begin
            state       <= state_nx;
            wr_ptr      <= wr_ptr_nx;
            rd_ptr      <= rd_ptr_nx;
            ni_r        <= ni_nx;
            cnt         <= cnt_nx;
            cache_valid <= valid_nx;
            err_r       <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        wr_ptr_nx = wr_ptr;
        rd_ptr_nx = rd_ptr;
        ni_nx     = ni_r;
        cnt_nx    = cnt;
        valid_nx  = cache_valid;
        err_nx    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.do_en) begin
                    if (do_ok) begin
                        ni_nx     = bus.ni;
                        cnt_nx    = bus.k - 1'b1;
                        wr_ptr_nx = '0;
                        valid_nx  = 1'b0;
                        state_nx  = ST_LOAD;
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (bus.redo_en) begin
                    // cnt counts remaining replay passes; redo replays all k
                    if (redo_ok) begin
                        cnt_nx    = bus.k;
                        rd_ptr_nx = '0;
                        state_nx  = ST_LOOP;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                err_nx    = req;
                mem_we    = 1'b1;
                wr_ptr_nx = wr_ptr + 1'b1;
                if (wr_ptr == ni_r - 1'b1) begin
                    valid_nx = 1'b1;
                    if (cnt == '0) begin
                        state_nx = ST_IDLE;
                    end else begin
                        rd_ptr_nx = '0;
                        state_nx  = ST_LOOP;
                    end
                end
            end
            ST_LOOP: begin
                err_nx = req;
                if (rd_ptr == ni_r - 1'b1) begin
                    rd_ptr_nx = '0;
                    cnt_nx    = cnt - 1'b1;
                    if (cnt == KW'(1)) begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    rd_ptr_nx = rd_ptr + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    jtdsp16_cache_mem #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (NIW)
    ) u_mem (
        .clk   (clk),
        .cen   (bus.cen),
        .we    (mem_we),
        .waddr (wr_ptr),
        .din   (bus.rom_dout),
        .raddr (rd_ptr),
        .dout  (mem_rdata)
    );

    assign bus.busy       = (state != ST_IDLE);
    assign bus.cache_sel  = (state == ST_LOOP);
    assign bus.pc_hold    = (state == ST_LOOP);
    assign bus.cache_dout = (state == ST_LOOP) ? mem_rdata : '0;
    assign bus.err        = err_r;

endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_cache_ctrl.sv
`default_nettype none
// Randomized self-checking bench for jtdsp16_cache_ctrl against a
// slot-sequence model of do/redo loops.
module tb_jtdsp16_cache_ctrl;

    localparam int IW = 16;

    typedef struct {
        bit            sel;
        logic [IW-1:0] word;
    } slot_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [IW-1:0] model_w[$];
    bit            model_valid;

    jtdsp16_cache_ctrl_if #(.IW(IW)) bus ();

    jtdsp16_cache_ctrl #(.DEPTH(15), .IW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instruction slot; with tog an extra cen=0 cycle must leave outputs untouched.
    task automatic adv(input bit tog);
        logic [IW-1:0] d0;
        logic          s0, p0, b0;
        if (tog) begin
            d0 = bus.cache_dout; s0 = bus.cache_sel; p0 = bus.pc_hold; b0 = bus.busy;
            bus.cen = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (bus.cache_dout !== d0 || bus.cache_sel !== s0 || bus.pc_hold !== p0 || bus.busy !== b0) begin
                errors++;
                $display("FAIL cen_hold: dout=%h sel=%b hold=%b busy=%b, expected dout=%h sel=%b hold=%b busy=%b",
                         bus.cache_dout, bus.cache_sel, bus.pc_hold, bus.busy, d0, s0, p0, b0);
            end
            bus.cen = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.cen = 1'b1; bus.do_en = 1'b0; bus.redo_en = 1'b0;
        bus.ni = '0; bus.k = '0; bus.rom_dout = '0;
        model_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.cache_sel !== 1'b0 || bus.pc_hold !== 1'b0 || bus.busy !== 1'b0 ||
            bus.err !== 1'b0 || bus.cache_dout !== '0) begin
            errors++;
            $display("FAIL reset_outputs: sel=%b hold=%b busy=%b err=%b dout=%h, expected all zero",
                     bus.cache_sel, bus.pc_hold, bus.busy, bus.err, bus.cache_dout);
        end
        rst = 1'b1;
        adv(1'b0);
    endtask

    // inject: loop-phase slot where a nested do is attempted (-1 none)
    // abort:  slot where reset is pulsed (-1 none)
    task automatic test_do(input int ni, input int k, input bit tog,
                           input int inject, input int abort, input bit both);
        logic [IW-1:0] w[$];
        slot_t         q[$];
        logic [IW-1:0] exp_d;
        bit            exp_err;
        slot_t         sl;
        for (int i = 0; i < ni; i++) w.push_back(IW'($urandom));
        for (int i = 0; i < ni; i++) q.push_back('{1'b0, w[i]});
        for (int p = 1; p < k; p++)
            for (int i = 0; i < ni; i++) q.push_back('{1'b1, w[i]});

        bus.do_en = 1'b1; bus.redo_en = both; bus.ni = 4'(ni); bus.k = 7'(k);
        adv(tog);
        bus.do_en = 1'b0; bus.redo_en = 1'b0;
        model_valid = 1'b0;

        for (int s = 0; s < q.size(); s++) begin
            sl      = q[s];
            exp_err = (inject >= 0) && (s == inject + 1);
            exp_d   = sl.sel ? sl.word : '0;
            bus.rom_dout = sl.sel ? IW'($urandom) : sl.word;
            checks++;
            if (bus.cache_sel !== sl.sel || bus.pc_hold !== sl.sel || bus.busy !== 1'b1 ||
                bus.err !== exp_err || bus.cache_dout !== exp_d) begin
                errors++;
                $display("FAIL do_slot %0d (ni=%0d k=%0d): sel=%b hold=%b busy=%b err=%b dout=%h, expected sel=%b hold=%b busy=1 err=%b dout=%h",
                         s, ni, k, bus.cache_sel, bus.pc_hold, bus.busy, bus.err, bus.cache_dout,
                         sl.sel, sl.sel, exp_err, exp_d);
            end
            if (s == abort) begin
                rst = 1'b0;
                #1;
                checks++;
                if (bus.cache_sel !== 1'b0 || bus.pc_hold !== 1'b0 || bus.busy !== 1'b0 ||
                    bus.err !== 1'b0 || bus.cache_dout !== '0) begin
                    errors++;
                    $display("FAIL abort_reset: sel=%b hold=%b busy=%b err=%b dout=%h, expected all zero",
                             bus.cache_sel, bus.pc_hold, bus.busy, bus.err, bus.cache_dout);
                end
                @(posedge clk); #1;
                rst = 1'b1;
                model_valid = 1'b0;
                return;
            end
            if (s == inject) begin
                bus.do_en = 1'b1; bus.ni = 4'd1; bus.k = 7'd1;
            end
            adv(tog);
            bus.do_en = 1'b0;
        end
        model_w = w;
        model_valid = 1'b1;

        exp_err = (inject >= 0) && (inject == q.size() - 1);
        checks++;
        if (bus.busy !== 1'b0 || bus.cache_sel !== 1'b0 || bus.pc_hold !== 1'b0 ||
            bus.cache_dout !== '0 || bus.err !== exp_err) begin
            errors++;
            $display("FAIL do_end (ni=%0d k=%0d): busy=%b sel=%b hold=%b dout=%h err=%b, expected 0 0 0 0000 %b",
                     ni, k, bus.busy, bus.cache_sel, bus.pc_hold, bus.cache_dout, bus.err, exp_err);
        end
        adv(1'b0);
    endtask

    task automatic test_redo(input int k, input bit tog);
        slot_t q[$];
        slot_t sl;
        bus.redo_en = 1'b1; bus.k = 7'(k);
        adv(tog);
        bus.redo_en = 1'b0;
        if (!model_valid || k == 0) begin
            checks++;
            if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.cache_sel !== 1'b0) begin
                errors++;
                $display("FAIL redo_reject (k=%0d): err=%b busy=%b sel=%b, expected err=1 busy=0 sel=0",
                         k, bus.err, bus.busy, bus.cache_sel);
            end
            adv(tog);
            checks++;
            if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL redo_err_pulse: err=%b busy=%b, expected err=0 busy=0", bus.err, bus.busy);
            end
            return;
        end
        for (int p = 0; p < k; p++)
            foreach (model_w[i]) q.push_back('{1'b1, model_w[i]});
        for (int s = 0; s < q.size(); s++) begin
            sl = q[s];
            bus.rom_dout = IW'($urandom);
            checks++;
            if (bus.cache_sel !== 1'b1 || bus.pc_hold !== 1'b1 || bus.busy !== 1'b1 ||
                bus.err !== 1'b0 || bus.cache_dout !== sl.word) begin
                errors++;
                $display("FAIL redo_slot %0d (k=%0d): sel=%b hold=%b busy=%b err=%b dout=%h, expected 1 1 1 0 %h",
                         s, k, bus.cache_sel, bus.pc_hold, bus.busy, bus.err, bus.cache_dout, sl.word);
            end
            adv(tog);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.cache_sel !== 1'b0 || bus.pc_hold !== 1'b0) begin
            errors++;
            $display("FAIL redo_end (k=%0d): busy=%b sel=%b hold=%b, expected all zero",
                     k, bus.busy, bus.cache_sel, bus.pc_hold);
        end
    endtask

    task automatic test_do_reject(input int ni, input int k);
        bus.do_en = 1'b1; bus.ni = 4'(ni); bus.k = 7'(k);
        adv(1'b0);
        bus.do_en = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL do_reject (ni=%0d k=%0d): err=%b busy=%b, expected err=1 busy=0",
                     ni, k, bus.err, bus.busy);
        end
        adv(1'b0);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL do_reject_pulse: err=%b, expected 0", bus.err);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            test_do($urandom_range(15, 1), $urandom_range(5, 1), 1'($urandom), -1, -1, 1'($urandom));
            test_redo($urandom_range(4, 1), 1'($urandom));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_redo(5, 1'b0);                 // no valid block after reset
        test_do_reject(0, 3);
        test_do_reject(3, 0);
        test_do(3, 4, 1'b0, -1, -1, 1'b0);  // basic do, 3 load + 9 replay
        test_do(2, 1, 1'b0, -1, -1, 1'b0);  // k=1: no replay phase
        test_redo(2, 1'b0);
        test_redo(0, 1'b0);
        test_do(3, 4, 1'b0, 5, -1, 1'b0);   // nested do mid-loop
        test_do(4, 3, 1'b0, -1, 6, 1'b0);   // reset mid-loop
        test_redo(2, 1'b0);
        test_do(4, 2, 1'b1, -1, -1, 1'b0);  // cen toggling
        test_do(3, 2, 1'b0, -1, -1, 1'b1);  // do and redo together
        test_do(15, 127, 1'b0, -1, -1, 1'b0);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
